spi_slave_core: RTL and testbench
=================================

# spi_slave_core

- SPI responder (slave) for the board-side end of the team's SPI links; the other end of the SPI master core.
- Oversamples the external SCLK/MOSI/SS_N in the system clock domain and shifts 8-bit frames MSB first in all four CPOL/CPHA modes.
- Presents received bytes and accepts transmit bytes through a simple register-style handshake for the local processor.

## Interface
- SYNC_STAGES, 2: synchronizer depth for spi_sclk, spi_mosi and spi_ss_n (legal values 2..3).
- clk  in  1  system clock; every register is clocked on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpol  in  1  idle SCLK level; latched on the SS_N falling edge.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on the SS_N falling edge.
- spi_sclk  in  1  SCLK from the master (asynchronous).
- spi_mosi  in  1  master-out data (asynchronous).
- spi_ss_n  in  1  select, active-low (asynchronous).
- spi_miso  out  1  slave-out data, registered.
- spi_miso_oe  out  1  MISO output enable; high only while selected.
- tx_data  in  8  next byte to send.
- tx_wr  in  1  one-cycle pulse that writes tx_data into the TX buffer.
- tx_empty  out  1  TX buffer empty.
- rx_data  out  8  last completed received byte.
- rx_valid  out  1  rx_data unread; held until rx_rd.
- rx_rd  in  1  one-cycle pulse that acknowledges rx_data.
- rx_overrun  out  1  sticky overrun flag.
- ovr_clr  in  1  one-cycle pulse that clears rx_overrun.
- busy  out  1  high while in ACTIVE.

## Operation
- **Synchronization:**
  - spi_sclk, spi_mosi and spi_ss_n pass through SYNC_STAGES flops, plus one history flop for edge detection.
  - Leading edge: SCLK leaves the cpol level. Trailing edge: SCLK returns to it.
  - Sample event: leading edge if cpha=0, trailing edge if cpha=1.
  - Drive event: trailing edge if cpha=0, leading edge if cpha=1.
- **FSM states: IDLE and ACTIVE.**
  - IDLE → ACTIVE on a synchronized SS_N falling edge.
    - Latch cpol/cpha; clear rx_cnt and tx_cnt.
    - Raise spi_miso_oe.
    - If cpha=0, perform a drive event with tx_cnt=0 in the same cycle.
  - ACTIVE → IDLE on a synchronized SS_N rising edge, which takes priority over a simultaneous SCLK edge.
    - Discard any partial RX byte.
    - Lower spi_miso_oe; spi_miso ← 0.
    - Leave the TX buffer untouched.
  - SCLK edges in IDLE are ignored.
- **Drive event:**
  - If tx_cnt==0: load the TX buffer into tx_shift, or 8'h00 if tx_empty; spi_miso ← bit 7; tx_empty ← 1.
  - Otherwise shift left and spi_miso ← next bit.
  - tx_cnt increments modulo 8.
- **Sample event:**
  - rx_shift ← {rx_shift[6:0], mosi_sync}; rx_cnt increments.
  - On the 8th sample: rx_data ← the completed byte, rx_valid ← 1, rx_cnt ← 0.
- **Simultaneous events:**
  - tx_wr in the same cycle as a load: the load consumes the old contents (or 8'h00). The written byte then fills the buffer, so tx_empty ends at 0.
  - tx_wr while the buffer is full: overwrites the buffer.
  - rx_rd in the same cycle as byte completion: the new byte wins, rx_valid stays 1, and no overrun is flagged.
  - Byte completion while rx_valid=1 with no rx_rd: rx_data is overwritten and the overrun condition fires.
- **Reset values:** spi_miso=0, spi_miso_oe=0, rx_data=0, rx_valid=0, tx_empty=1, rx_overrun=0, busy=0, state IDLE.
- **Reset mid-frame:** abandons the frame immediately with no completion pulse.
- **cpol/cpha changes while selected:** ignored until the next selection.

## Timing
- Pin-to-detect latency is SYNC_STAGES+1 clk.
- spi_miso changes SYNC_STAGES+2 clk after the drive edge at the pin.
- rx_valid rises SYNC_STAGES+2 clk after the 8th sample edge at the pin.
- Required SCLK high and low times: at least SYNC_STAGES+3 clk each (5 clk at the default).
- Required gap from SS_N falling to the first SCLK edge: at least SYNC_STAGES+3 clk.
- Required gap from the last SCLK edge to SS_N rising: at least SYNC_STAGES+3 clk.
- Back-to-back frames without deselect are supported; tx_cnt and rx_cnt wrap.

## Configuration
- **SPI_SLV_OVERRUN_EN defined:**
  - rx_overrun sets on byte completion while rx_valid=1 and rx_rd=0.
  - It holds until an ovr_clr pulse or reset; ovr_clr and a set in the same cycle leave it set.
- **SPI_SLV_OVERRUN_EN undefined:** rx_overrun is tied to 0 and ovr_clr is ignored. Overwrite behaviour is unchanged.

## Test plan
- **Mode 0, RX path:**
  - Stimulus: tx_wr 8'hA5, then the master sends 8'h3C at 8 clk per SCLK half.
  - Expected: MISO bits read 1,0,1,0,0,1,0,1; rx_data=8'h3C with rx_valid=1; tx_empty=1 after the first drive.
- **All four modes:**
  - Stimulus: master exchanges 8'hC3 ↔ 8'h5A in each CPOL/CPHA combination.
  - Expected: bit-exact data in both directions.
- **Back-to-back and underrun:**
  - Stimulus: two bytes 8'h01, 8'h02 without deselect; only the first is preloaded in TX.
  - Expected: two rx_valid events; the second MISO byte is 8'h00.
- **Abort:**
  - Stimulus: SS_N rises after 5 bits.
  - Expected: no rx_valid; spi_miso_oe=0; the next frame 8'hFF is received correctly.
- **Overrun (macro defined):**
  - Stimulus: two bytes received without rx_rd.
  - Expected: rx_overrun=1 and rx_data holds the second byte; ovr_clr returns rx_overrun to 0.
  - With the macro undefined, rx_overrun stays 0.
- **Reset:**
  - Stimulus: rst_n low mid-byte.
  - Expected: every output at its reset value within the same cycle, with no completion pulse.

Source files
------------

// File: rtl/spi_slave_core_if.sv
// spi_slave_core_if: SPI pins, mode selects and the processor-side RX/TX handshake of spi_slave_core.
// The slave modport is the core's view; the master modport is the view of whatever drives the core.
interface spi_slave_core_if;
    logic       cpol;
    logic       cpha;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_ss_n;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_empty;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_rd;
    logic       rx_overrun;
    logic       ovr_clr;
    logic       busy;

    modport slave (
        input  cpol, cpha, spi_sclk, spi_mosi, spi_ss_n,
        input  tx_data, tx_wr, rx_rd, ovr_clr,
        output spi_miso, spi_miso_oe, tx_empty, rx_data, rx_valid, rx_overrun, busy
    );

    modport master (
        output cpol, cpha, spi_sclk, spi_mosi, spi_ss_n,
        output tx_data, tx_wr, rx_rd, ovr_clr,
        input  spi_miso, spi_miso_oe, tx_empty, rx_data, rx_valid, rx_overrun, busy
    );
endinterface

// File: rtl/spi_slave_core.sv
// spi_slave_core: oversampled SPI responder, 8-bit MSB-first frames in all CPOL/CPHA modes.
// Define SPI_SLV_OVERRUN_EN to enable the sticky rx_overrun flag (tied to 0 otherwise).
module spi_slave_core #(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_slave_core_if.slave  bus_if
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    // Synchronizer chains plus one history flop each for edge detection
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic                   sclk_hist_q;
    logic                   ss_hist_q;

    logic sclk_s;
    logic mosi_s;
    logic ss_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sclk_hist_q <= 1'b0;
            ss_hist_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus_if.spi_sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus_if.spi_mosi};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus_if.spi_ss_n};
            sclk_hist_q <= sclk_s;
            ss_hist_q   <= ss_s;
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];

    state_t     state_q;
    logic       cpol_q;
    logic       cpha_q;
    logic [2:0] rx_cnt_q;
    logic [2:0] tx_cnt_q;
    logic [7:0] rx_shift_q;
    logic [7:0] tx_shift_q;
    logic [7:0] tx_buf_q;
    logic       tx_empty_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       miso_q;
    logic       miso_oe_q;
    logic       busy_q;
    logic       rx_overrun_q;

    logic       ss_fall;
    logic       ss_rise;
    logic       sclk_lead;
    logic       sclk_trail;
    logic       sample_ev;
    logic       drive_ev;
    logic [7:0] tx_load_d;
    logic [7:0] rx_byte_d;
    logic       rx_done_d;

    assign ss_fall    = ss_hist_q & ~ss_s;
    assign ss_rise    = ~ss_hist_q & ss_s;
    // Edges are classified against the cpol latched at selection, not the live input
    assign sclk_lead  = (sclk_hist_q == cpol_q) && (sclk_s != cpol_q);
    assign sclk_trail = (sclk_hist_q != cpol_q) && (sclk_s == cpol_q);
    assign sample_ev  = cpha_q ? sclk_trail : sclk_lead;
    assign drive_ev   = cpha_q ? sclk_lead : sclk_trail;

    assign tx_load_d  = tx_empty_q ? 8'h00 : tx_buf_q;
    assign rx_byte_d  = {rx_shift_q[6:0], mosi_s};
    assign rx_done_d  = (state_q == ACTIVE) && !ss_rise && sample_ev && (rx_cnt_q == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            rx_cnt_q   <= 3'd0;
            tx_cnt_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            tx_shift_q <= 8'h00;
            tx_buf_q   <= 8'h00;
            tx_empty_q <= 1'b1;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // Acknowledge first so a completion in the same cycle re-asserts rx_valid
            if (bus_if.rx_rd) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (ss_fall) begin
                        state_q   <= ACTIVE;
                        busy_q    <= 1'b1;
                        miso_oe_q <= 1'b1;
                        cpol_q    <= bus_if.cpol;
                        cpha_q    <= bus_if.cpha;
                        rx_cnt_q  <= 3'd0;
                        if (!bus_if.cpha) begin
                            tx_shift_q <= tx_load_d;
                            miso_q     <= tx_load_d[7];
                            tx_empty_q <= 1'b1;
                            tx_cnt_q   <= 3'd1;
                        end else begin
                            tx_cnt_q   <= 3'd0;
                        end
                    end
                end

                ACTIVE: begin
                    if (ss_rise) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                        miso_q    <= 1'b0;
                        rx_cnt_q  <= 3'd0;
                    end else begin
                        if (drive_ev) begin
                            if (tx_cnt_q == 3'd0) begin
                                tx_shift_q <= tx_load_d;
                                miso_q     <= tx_load_d[7];
                                tx_empty_q <= 1'b1;
                            end else begin
                                tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                                miso_q     <= tx_shift_q[6];
                            end
                            tx_cnt_q <= tx_cnt_q + 3'd1;
                        end
                        if (sample_ev) begin
                            rx_shift_q <= rx_byte_d;
                            rx_cnt_q   <= rx_cnt_q + 3'd1;
                            if (rx_cnt_q == 3'd7) begin
                                rx_data_q  <= rx_byte_d;
                                rx_valid_q <= 1'b1;
                            end
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase

            // A write after a same-cycle load refills the buffer
            if (bus_if.tx_wr) begin
                tx_buf_q   <= bus_if.tx_data;
                tx_empty_q <= 1'b0;
            end
        end
    end

`ifdef SPI_SLV_OVERRUN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_overrun_q <= 1'b0;
        end else if (rx_done_d && rx_valid_q && !bus_if.rx_rd) begin
            rx_overrun_q <= 1'b1;
        end else if (bus_if.ovr_clr) begin
            rx_overrun_q <= 1'b0;
        end
    end
`else
    logic unused_ovr;
    assign unused_ovr   = bus_if.ovr_clr ^ rx_done_d;
    assign rx_overrun_q = 1'b0;
`endif

    assign bus_if.spi_miso    = miso_q;
    assign bus_if.spi_miso_oe = miso_oe_q;
    assign bus_if.tx_empty    = tx_empty_q;
    assign bus_if.rx_data     = rx_data_q;
    assign bus_if.rx_valid    = rx_valid_q;
    assign bus_if.rx_overrun  = rx_overrun_q;
    assign bus_if.busy        = busy_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: directed SPI master model with byte scoreboards for MISO and received data.
module tb_spi_slave_core;
    localparam int HALF = 8;

`ifdef SPI_SLV_OVERRUN_EN
    localparam logic [7:0] OVR_EXP = 8'd1;
`else
    localparam logic [7:0] OVR_EXP = 8'd0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_slave_core_if bus ();

    spi_slave_core #(.SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_mi_q[$];
    logic [7:0] last_mi;
    logic [7:0] pat;
    logic [7:0] part_mi;
    logic [1:0] mb;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_write(input logic [7:0] d);
        @(negedge clk);
        bus.tx_data = d;
        bus.tx_wr   = 1'b1;
        @(negedge clk);
        bus.tx_wr   = 1'b0;
    endtask

    task automatic rx_read();
        @(negedge clk);
        bus.rx_rd = 1'b1;
        @(negedge clk);
        bus.rx_rd = 1'b0;
        check("rx_valid_after_rd", {7'd0, bus.rx_valid}, 8'd0);
    endtask

    task automatic select(input logic pol, input logic pha);
        bus.cpol     = pol;
        bus.cpha     = pha;
        bus.spi_sclk = pol;
        tick(HALF);
        bus.spi_ss_n = 1'b0;
        tick(HALF);
    endtask

    task automatic deselect();
        tick(HALF);
        bus.spi_ss_n = 1'b1;
        tick(HALF);
    endtask

    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!bus.cpha) begin
                bus.spi_mosi = mo[7-i];
                tick(HALF);
                bus.spi_sclk = ~bus.cpol;
                mi[7-i]      = bus.spi_miso;
                tick(HALF);
                bus.spi_sclk = bus.cpol;
            end else begin
                bus.spi_sclk = ~bus.cpol;
                bus.spi_mosi = mo[7-i];
                tick(HALF);
                bus.spi_sclk = bus.cpol;
                mi[7-i]      = bus.spi_miso;
                tick(HALF);
            end
        end
    endtask

    task automatic wait_rx(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            if (bus.rx_valid === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic run_byte(input logic [7:0] mo, input logic [7:0] exp_mi,
                            input bit expect_rx, input bit do_rd);
        logic [7:0] mi;
        bit         seen;
        exp_mi_q.push_back(exp_mi);
        if (expect_rx) exp_rx_q.push_back(mo);
        xfer(mo, 8, mi);
        last_mi = mi;
        $display("xfer cpol=%0b cpha=%0b mosi=%02h miso=%02h rx_data=%02h",
                 bus.cpol, bus.cpha, mo, mi, bus.rx_data);
        check("miso_byte", mi, exp_mi_q.pop_front());
        if (expect_rx) begin
            wait_rx(seen);
            check("rx_valid", {7'd0, seen}, 8'd1);
            check("rx_data", bus.rx_data, exp_rx_q.pop_front());
            if (do_rd) rx_read();
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_miso"},   {7'd0, bus.spi_miso},    8'd0);
        check({tag, "_oe"},     {7'd0, bus.spi_miso_oe}, 8'd0);
        check({tag, "_busy"},   {7'd0, bus.busy},        8'd0);
    endtask

    initial begin
        bus.cpol = 1'b0; bus.cpha = 1'b0;
        bus.spi_sclk = 1'b0; bus.spi_mosi = 1'b0; bus.spi_ss_n = 1'b1;
        bus.tx_data = 8'h00; bus.tx_wr = 1'b0; bus.rx_rd = 1'b0; bus.ovr_clr = 1'b0;

        // Reset state
        tick(3);
        check_idle_outputs("rst");
        check("rst_rx_data",  bus.rx_data, 8'h00);
        check("rst_rx_valid", {7'd0, bus.rx_valid},   8'd0);
        check("rst_tx_empty", {7'd0, bus.tx_empty},   8'd1);
        check("rst_overrun",  {7'd0, bus.rx_overrun}, 8'd0);
        rst_n = 1'b1;
        tick(4);

        // Mode 0, RX path with per-bit MISO check
        tx_write(8'hA5);
        check("tx_empty_after_wr", {7'd0, bus.tx_empty}, 8'd0);
        select(1'b0, 1'b0);
        check("tx_empty_after_drive", {7'd0, bus.tx_empty}, 8'd1);
        check("oe_selected",   {7'd0, bus.spi_miso_oe}, 8'd1);
        check("busy_selected", {7'd0, bus.busy},        8'd1);
        run_byte(8'h3C, 8'hA5, 1'b1, 1'b1);
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) check("miso_bit", {7'd0, last_mi[7-i]}, {7'd0, pat[7-i]});
        deselect();
        check_idle_outputs("desel");

        // All four modes
        for (int m = 0; m < 4; m++) begin
            mb = m[1:0];
            tx_write(8'h5A);
            select(mb[1], mb[0]);
            run_byte(8'hC3, 8'h5A, 1'b1, 1'b1);
            deselect();
        end

        // Back-to-back with TX underrun on the second byte
        tx_write(8'h96);
        select(1'b0, 1'b0);
        run_byte(8'h01, 8'h96, 1'b1, 1'b1);
        run_byte(8'h02, 8'h00, 1'b1, 1'b1);
        deselect();

        // Abort after 5 bits, then a clean frame
        select(1'b0, 1'b0);
        xfer(8'hE7, 5, part_mi);
        deselect();
        check("abort_rx_valid", {7'd0, bus.rx_valid}, 8'd0);
        check_idle_outputs("abort");
        tx_write(8'h3C);
        select(1'b0, 1'b0);
        run_byte(8'hFF, 8'h3C, 1'b1, 1'b1);
        deselect();

        // Overrun: two completions without rx_rd
        select(1'b1, 1'b1);
        run_byte(8'h11, 8'h00, 1'b1, 1'b0);
        run_byte(8'h22, 8'h00, 1'b1, 1'b0);
        deselect();
        check("overrun_set", {7'd0, bus.rx_overrun}, OVR_EXP);
        @(negedge clk);
        bus.ovr_clr = 1'b1;
        @(negedge clk);
        bus.ovr_clr = 1'b0;
        check("overrun_clr", {7'd0, bus.rx_overrun}, 8'd0);

        // Reset mid-byte while rx_valid and a full TX buffer are pending
        select(1'b1, 1'b1);
        xfer(8'hB4, 4, part_mi);
        tx_write(8'h77);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        check("midrst_rx_data",  bus.rx_data, 8'h00);
        check("midrst_rx_valid", {7'd0, bus.rx_valid},   8'd0);
        check("midrst_tx_empty", {7'd0, bus.tx_empty},   8'd1);
        check("midrst_overrun",  {7'd0, bus.rx_overrun}, 8'd0);
        bus.spi_ss_n = 1'b1;
        tick(4);
        rst_n = 1'b1;
        tick(30);
        check("postrst_rx_valid", {7'd0, bus.rx_valid}, 8'd0);
        check("postrst_busy",     {7'd0, bus.busy},     8'd0);

        // Recovery frame after reset
        tx_write(8'h81);
        select(1'b0, 1'b0);
        run_byte(8'h7E, 8'h81, 1'b1, 1'b1);
        deselect();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
